// File: rtl/soc_event_dc_src_if.sv
// Event request channel into the SoC-side writer of the dual-clock event buffer.
// The producer holds evt_valid/evt_data until evt_ready is high on the same cycle.
interface soc_event_dc_src_if #(
  parameter int EVNT_WIDTH = 8
);
  logic                  evt_valid;
  logic [EVNT_WIDTH-1:0] evt_data;
  logic                  evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/soc_event_dc_src.sv
// SoC-side writer of the dual-clock event channel: buffers events and publishes a Johnson write token.
// Token updates one cycle after an accept; when full it back-pressures, or with DROP_ON_FULL drops and counts.
module soc_event_dc_src #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  soc_event_dc_src_if.slave                  evt,
  output logic [BUFFER_WIDTH-1:0]            events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
  output logic [$clog2(BUFFER_WIDTH)+1-1:0]  fill_o,
  output logic [15:0]                        drop_cnt_o
);

  localparam int BW = BUFFER_WIDTH;
  localparam int EW = EVNT_WIDTH;
  localparam int IW = $clog2(BUFFER_WIDTH) + 1;
  localparam int NS = 2 * BUFFER_WIDTH;

  logic [BW-1:0] wt;
  logic [BW-1:0] rp_m;
  logic [BW-1:0] rp_s;
  logic [EW-1:0] slots [BW];
  logic [15:0]   drop_cnt;

  logic [IW-1:0] idx_wt;
  logic [IW-1:0] idx_rp;
  logic [IW-1:0] wslot;
  logic          full;
  logic          ready;
  logic          push;
  logic          drop;

  // Johnson state -> linear index in 0..2*BW-1
  function automatic logic [IW-1:0] idx_of(input logic [BW-1:0] x);
    logic [IW-1:0] pc;
    pc = '0;
    for (int i = 0; i < BW; i++) pc = pc + IW'(x[i]);
    if (x[0])          return pc;
    else if (x == '0)  return '0;
    else               return IW'(NS) - pc;
  endfunction

  always_comb begin
    idx_wt = idx_of(wt);
    idx_rp = idx_of(rp_s);
    wslot  = IW'(int'(idx_wt) % BW);
    full   = (wt == ~rp_s);
    ready  = (DROP_ON_FULL != 0) ? 1'b1 : ~full;
    push   = evt.evt_valid & ready & ~full;
    drop   = (DROP_ON_FULL != 0) & evt.evt_valid & full;
    // Modulo-2*BW difference; the IW'(NS) term is zero when 2*BW is a power of two
    fill_o = idx_wt - idx_rp;
    if (idx_wt < idx_rp) fill_o = fill_o + IW'(NS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wt       <= '0;
      rp_m     <= '0;
      rp_s     <= '0;
      drop_cnt <= '0;
      for (int s = 0; s < BW; s++) slots[s] <= '0;
    end else begin
      rp_m <= events_rp_i;
      rp_s <= rp_m;
      if (push) begin
        wt <= {wt[BW-2:0], ~wt[BW-1]};
        for (int s = 0; s < BW; s++)
          if (wslot == IW'(s)) slots[s] <= evt.evt_data;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < BW; g++) begin : g_da
    assign events_da_o[g*EW +: EW] = slots[g];
  end

  assign evt.evt_ready = ready;
  assign events_wt_o   = wt;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_soc_event_dc_src.sv
// Directed bench for soc_event_dc_src: back-pressure instance (a) and drop-on-full instance (b), BW=4, EW=8.
module tb_soc_event_dc_src;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  rp_a, rp_b;
  logic [3:0]  wt_a, wt_b;
  logic [31:0] da_a, da_b;
  logic [2:0]  fill_a, fill_b;
  logic [15:0] drop_a, drop_b;
  int checks = 0;
  int errors = 0;

  soc_event_dc_src_if #(.EVNT_WIDTH(8)) ifa ();
  soc_event_dc_src_if #(.EVNT_WIDTH(8)) ifb ();

  soc_event_dc_src #(.BUFFER_WIDTH(4), .EVNT_WIDTH(8), .DROP_ON_FULL(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .evt(ifa.slave), .events_wt_o(wt_a),
    .events_rp_i(rp_a), .events_da_o(da_a), .fill_o(fill_a), .drop_cnt_o(drop_a)
  );

  soc_event_dc_src #(.BUFFER_WIDTH(4), .EVNT_WIDTH(8), .DROP_ON_FULL(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .evt(ifb.slave), .events_wt_o(wt_b),
    .events_rp_i(rp_b), .events_da_o(da_b), .fill_o(fill_b), .drop_cnt_o(drop_b)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] jn(input int k);
    logic [3:0] x;
    x = 4'b0000;
    for (int i = 0; i < k; i++) x = {x[2:0], ~x[3]};
    return x;
  endfunction

  task automatic test_reset();
    rp_a = 4'b0; rp_b = 4'b0;
    ifa.evt_valid = 1'b0; ifa.evt_data = 8'h00;
    ifb.evt_valid = 1'b0; ifb.evt_data = 8'h00;
    #1 rst_n = 1'b0;
    #3;
    checks++; if (wt_a !== 4'b0000) begin errors++; $display("FAIL reset_wt got %b want 0000", wt_a); end
    checks++; if (ifa.evt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifa.evt_ready); end
    checks++; if (fill_a !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_a); end
    checks++; if (drop_b !== 16'h0) begin errors++; $display("FAIL reset_drop got %h want 0", drop_b); end
    #20 rst_n = 1'b1;
    // one push, then an asynchronous reset in the middle of a cycle
    @(posedge clk); #1;
    ifa.evt_valid = 1'b1; ifa.evt_data = 8'h11;
    @(posedge clk); #1;
    ifa.evt_valid = 1'b0; ifa.evt_data = 8'hxx;
    checks++; if (wt_a !== 4'b0001 || da_a !== 32'h00000011) begin errors++; $display("FAIL pre_reset_push got wt=%b da=%h want 0001 00000011", wt_a, da_a); end
    @(posedge clk); #1;
    checks++; if (da_a !== 32'h00000011) begin errors++; $display("FAIL x_data_gated got %h want 00000011", da_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wt_a !== 4'b0000 || da_a !== 32'h0 || fill_a !== 3'd0 || ifa.evt_ready !== 1'b1 || drop_a !== 16'h0)
      begin errors++; $display("FAIL async_reset got wt=%b da=%h fill=%0d rdy=%b drop=%h want 0000 0 0 1 0", wt_a, da_a, fill_a, ifa.evt_ready, drop_a); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fill_full();
    logic [3:0] exp_wt [4];
    exp_wt[0] = 4'b0001; exp_wt[1] = 4'b0011; exp_wt[2] = 4'b0111; exp_wt[3] = 4'b1111;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ifa.evt_valid = 1'b1; ifa.evt_data = 8'(8'h11 * (i + 1));
      @(posedge clk); #1;
      checks++; if (wt_a !== exp_wt[i] || fill_a !== 3'(i + 1))
        begin errors++; $display("FAIL fill_step%0d got wt=%b fill=%0d want %b %0d", i, wt_a, fill_a, exp_wt[i], i + 1); end
    end
    checks++; if (ifa.evt_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ifa.evt_ready); end
    checks++; if (da_a !== 32'h44332211) begin errors++; $display("FAIL full_data got %h want 44332211", da_a); end
    ifa.evt_data = 8'h99;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (wt_a !== 4'b1111 || da_a !== 32'h44332211 || ifa.evt_ready !== 1'b0)
      begin errors++; $display("FAIL full_hold got wt=%b da=%h rdy=%b want 1111 44332211 0", wt_a, da_a, ifa.evt_ready); end
    checks++; if (drop_a !== 16'h0) begin errors++; $display("FAIL nodrop_count got %h want 0", drop_a); end
    ifa.evt_valid = 1'b0;
  endtask

  task automatic test_free_reuse();
    rp_a = 4'b0001;
    @(posedge clk); #1;
    checks++; if (ifa.evt_ready !== 1'b0 || fill_a !== 3'd4)
      begin errors++; $display("FAIL free_1cyc got rdy=%b fill=%0d want 0 4", ifa.evt_ready, fill_a); end
    @(posedge clk); #1;
    checks++; if (ifa.evt_ready !== 1'b1 || fill_a !== 3'd3)
      begin errors++; $display("FAIL free_2cyc got rdy=%b fill=%0d want 1 3", ifa.evt_ready, fill_a); end
    ifa.evt_valid = 1'b1; ifa.evt_data = 8'h55;
    @(posedge clk); #1;
    ifa.evt_valid = 1'b0;
    checks++; if (wt_a !== 4'b1110 || da_a !== 32'h44332255 || ifa.evt_ready !== 1'b0 || fill_a !== 3'd4)
      begin errors++; $display("FAIL reuse got wt=%b da=%h rdy=%b fill=%0d want 1110 44332255 0 4", wt_a, da_a, ifa.evt_ready, fill_a); end
  endtask

  task automatic test_drop();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ifb.evt_valid = 1'b1; ifb.evt_data = 8'(i + 1);
      @(posedge clk); #1;
    end
    checks++; if (wt_b !== 4'b1111 || da_b !== 32'h04030201)
      begin errors++; $display("FAIL drop_fill got wt=%b da=%h want 1111 04030201", wt_b, da_b); end
    ifb.evt_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifb.evt_ready !== 1'b1) begin errors++; $display("FAIL drop_ready%0d got %b want 1", i, ifb.evt_ready); end
      @(posedge clk); #1;
    end
    ifb.evt_valid = 1'b0;
    checks++; if (drop_b !== 16'd3 || wt_b !== 4'b1111 || da_b !== 32'h04030201)
      begin errors++; $display("FAIL drop_three got cnt=%0d wt=%b da=%h want 3 1111 04030201", drop_b, wt_b, da_b); end
  endtask

  task automatic test_drop_saturation();
    ifb.evt_valid = 1'b1; ifb.evt_data = 8'hAA;
    repeat (65531) @(posedge clk);
    #1;
    checks++; if (drop_b !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", drop_b); end
    @(posedge clk); #1;
    checks++; if (drop_b !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", drop_b); end
    repeat (5) @(posedge clk);
    #1;
    ifb.evt_valid = 1'b0;
    checks++; if (drop_b !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", drop_b); end
  endtask

  task automatic test_wrap();
    int hist [100];
    int n;
    int r;
    int tgt;
    logic will_acc;
    @(negedge clk) rst_n = 1'b0;
    rp_a = 4'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n = 0; r = 0;
    for (int cyc = 0; cyc < 80 && (n < 8 || r < 8); cyc++) begin
      checks++; if (wt_a !== jn(n)) begin errors++; $display("FAIL wrap_wt c%0d got %b want %b", cyc, wt_a, jn(n)); end
      checks++; if (fill_a > 3'd4 || ifa.evt_ready !== (fill_a != 3'd4))
        begin errors++; $display("FAIL wrap_fill c%0d got fill=%0d rdy=%b want fill<=4 rdy=(fill!=4)", cyc, fill_a, ifa.evt_ready); end
      hist[cyc] = n;
      tgt = (cyc >= 3) ? hist[cyc - 3] : 0;
      while (r < tgt) begin
        checks++; if (da_a[(r % 4)*8 +: 8] !== 8'(8'hA0 + r))
          begin errors++; $display("FAIL wrap_read e%0d got %h want %h", r, da_a[(r % 4)*8 +: 8], 8'(8'hA0 + r)); end
        r++;
      end
      rp_a = jn(r);
      will_acc = 1'b0;
      if (n < 8) begin
        ifa.evt_valid = 1'b1; ifa.evt_data = 8'(8'hA0 + n);
        will_acc = ifa.evt_ready;
      end else begin
        ifa.evt_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (will_acc) begin
        checks++; if (da_a[(n % 4)*8 +: 8] !== 8'(8'hA0 + n))
          begin errors++; $display("FAIL wrap_slot e%0d got %h want %h", n, da_a[(n % 4)*8 +: 8], 8'(8'hA0 + n)); end
        n++;
      end
    end
    ifa.evt_valid = 1'b0;
    checks++; if (n !== 8 || r !== 8) begin errors++; $display("FAIL wrap_progress got pushed=%0d read=%0d want 8 8", n, r); end
    checks++; if (wt_a !== 4'b0000) begin errors++; $display("FAIL wrap_final got %b want 0000", wt_a); end
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_free_reuse();
    test_drop();
    test_drop_saturation();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
